// File: rtl/mem_to_apb_master.sv
// Bridges the core req/gnt memory port onto an APB master (SETUP/ACCESS sequencing),
// returning a registered response pulse and aborting ACCESS phases that never see PREADY.
module mem_to_apb_master #(
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [ADDR_SIZE-1:0]   addr_i,
  input  logic [DATA_SIZE-1:0]   wdata_i,
  input  logic [DATA_SIZE/8-1:0] strb_i,
  input  logic                   we_i,
  output logic                   rvalid_o,
  output logic [DATA_SIZE-1:0]   rdata_o,
  output logic                   err_o,
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic                   PWRITE,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic [DATA_SIZE/8-1:0] PSTRB,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int STRB_SIZE = DATA_SIZE / 8;
  // A disabled timeout still gets a 1-bit counter so the declarations stay legal.
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             gnt_s;
  logic             done_s;
  logic             abort_s;

  // Grant, completion and timeout-abort decode for the current cycle.
  always_comb begin
    gnt_s   = 1'b0;
    done_s  = 1'b0;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        gnt_s = req_i;
      end
      SETUP: begin
        gnt_s = 1'b0;
      end
      ACCESS: begin
        if (PREADY) begin
          done_s = 1'b1;
          gnt_s  = req_i;
        end else begin
          gnt_s   = 1'b0;
          abort_s = (TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST);
        end
      end
      default: begin
        gnt_s = 1'b0;
      end
    endcase
  end

  assign gnt_o = gnt_s;

  // APB sequencing FSM with request capture and registered response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= {DATA_SIZE{1'b0}};
      PADDR    <= {ADDR_SIZE{1'b0}};
      PWDATA   <= {DATA_SIZE{1'b0}};
      PSTRB    <= {STRB_SIZE{1'b0}};
      PWRITE   <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      if (gnt_s) begin
        PADDR  <= addr_i;
        PWDATA <= wdata_i;
        PSTRB  <= we_i ? strb_i : {STRB_SIZE{1'b0}};
        PWRITE <= we_i;
      end
      case (state_r)
        IDLE: begin
          PENABLE <= 1'b0;
          if (gnt_s) begin
            state_r <= SETUP;
            PSEL    <= 1'b1;
          end else begin
            PSEL    <= 1'b0;
          end
        end
        SETUP: begin
          state_r <= ACCESS;
          PSEL    <= 1'b1;
          PENABLE <= 1'b1;
          cnt_r   <= {CNT_W{1'b0}};
        end
        ACCESS: begin
          if (done_s) begin
            rvalid_o <= 1'b1;
            err_o    <= PSLVERR;
            rdata_o  <= (!PWRITE && !PSLVERR) ? PRDATA : {DATA_SIZE{1'b0}};
            PENABLE  <= 1'b0;
            // A back-to-back grant skips IDLE and goes straight to SETUP.
            if (gnt_s) begin
              state_r <= SETUP;
              PSEL    <= 1'b1;
            end else begin
              state_r <= IDLE;
              PSEL    <= 1'b0;
            end
          end else if (abort_s) begin
            state_r  <= IDLE;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= {DATA_SIZE{1'b0}};
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_to_apb_master.sv
// Directed bench for mem_to_apb_master: a transaction-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_mem_to_apb_master;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [3:0]  strb_i = 4'd0;
  logic        we_i = 1'b0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA = 32'd0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_to_apb_master #(.ADDR_SIZE(32), .DATA_SIZE(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .we_i(we_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: answers after slv_wait not-ready ACCESS cycles; junk on PRDATA/PSLVERR otherwise.
  int          slv_wait = 0;
  logic        slv_never = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'd0;
  int          acc_n = 0;

  always @(posedge clk_i) begin
    #1;
    if (PSEL && PENABLE) begin
      if (!slv_never && acc_n >= slv_wait) begin
        PREADY  = 1'b1;
        PRDATA  = slv_rdata;
        PSLVERR = slv_err;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = 32'hBAD0_BAD0;
        PSLVERR = 1'b1;
      end
      acc_n = acc_n + 1;
    end else begin
      acc_n   = 0;
      PREADY  = 1'b0;
      PRDATA  = 32'h5A5A_5A5A;
      PSLVERR = 1'b1;
    end
  end

  // Reference model: a transaction is "active" from grant; age 1 is its SETUP cycle,
  // age k>=2 is ACCESS cycle number k-1.
  logic        m_active;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic        m_we, m_rvalid, m_err;

  always @(posedge clk_i or posedge rst_i) begin
    logic in_acc, fin, abt, take;
    if (rst_i) begin
      m_active <= 1'b0; m_age <= 0; m_addr <= 32'd0; m_wdata <= 32'd0; m_strb <= 4'd0;
      m_we <= 1'b0; m_rvalid <= 1'b0; m_err <= 1'b0; m_rdata <= 32'd0;
    end else begin
      in_acc = m_active && (m_age >= 2);
      fin    = in_acc && PREADY;
      abt    = in_acc && !PREADY && (TO != 0) && (m_age - 1 == TO);
      take   = req_i && (!m_active || fin);
      m_rvalid <= fin || abt;
      m_err    <= fin ? PSLVERR : abt;
      if (fin) m_rdata <= (m_we || PSLVERR) ? 32'd0 : PRDATA;
      else if (abt) m_rdata <= 32'd0;
      if (take) begin
        m_active <= 1'b1; m_age <= 1;
        m_addr <= addr_i; m_wdata <= wdata_i; m_we <= we_i;
        m_strb <= we_i ? strb_i : 4'd0;
      end else if (fin || abt) begin
        m_active <= 1'b0; m_age <= 0;
      end else if (m_active) begin
        m_age <= m_age + 1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk_i) begin
    logic exp_gnt;
    if (!rst_i) begin
      exp_gnt = req_i && (!m_active || (m_age >= 2 && PREADY));
      check("m_gnt", 32'(gnt_o), 32'(exp_gnt));
      check("m_psel", 32'(PSEL), 32'(m_active));
      check("m_penable", 32'(PENABLE), 32'(m_active && m_age >= 2));
      check("m_paddr", PADDR, m_addr);
      check("m_pwdata", PWDATA, m_wdata);
      check("m_pstrb", 32'(PSTRB), 32'(m_strb));
      check("m_pwrite", 32'(PWRITE), 32'(m_we));
      check("m_rvalid", 32'(rvalid_o), 32'(m_rvalid));
      check("m_err", 32'(err_o), 32'(m_err));
      check("m_rdata", rdata_o, m_rdata);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  task automatic req_put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w);
    req_i = 1'b1; addr_i = a; wdata_i = d; strb_i = s; we_i = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g_bits, s_bits, e_bits, v_bits;
    logic       g;
    int         grants;

    // Reset values
    step(); step(); neg();
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_pstrb", 32'(PSTRB), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    rst_i = 1'b0;

    // 1: zero-wait write
    step(); req_put(32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1); slv_wait = 0;
    neg(); check("t1_gnt", 32'(gnt_o), 32'd1);
    step(); req_i = 1'b0;
    neg(); check("t1_setup_psel", 32'(PSEL), 32'd1);
    check("t1_setup_pen", 32'(PENABLE), 32'd0);
    check("t1_pstrb", 32'(PSTRB), 32'hF);
    check("t1_paddr", PADDR, 32'h100);
    check("t1_pwdata", PWDATA, 32'hDEAD_BEEF);
    step(); neg();
    check("t1_access_pen", 32'(PENABLE), 32'd1);
    step(); neg();
    check("t1_rvalid", 32'(rvalid_o), 32'd1);
    check("t1_err", 32'(err_o), 32'd0);
    check("t1_rdata", rdata_o, 32'd0);
    check("t1_psel_drop", 32'(PSEL), 32'd0);
    step(); neg();
    check("t1_rvalid_pulse", 32'(rvalid_o), 32'd0);

    // 2: read with 3 wait states; PREADY lands on the timeout threshold cycle
    step(); req_put(32'h104, 32'd0, 4'hF, 1'b0); slv_wait = 3; slv_rdata = 32'h1234_5678;
    neg(); check("t2_gnt", 32'(gnt_o), 32'd1);
    step(); req_i = 1'b0;
    neg(); check("t2_pstrb_read", 32'(PSTRB), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(); neg();
      check("t2_psel", 32'(PSEL), 32'd1);
      check("t2_pen", 32'(PENABLE), 32'd1);
      check("t2_paddr", PADDR, 32'h104);
      check("t2_no_rvalid", 32'(rvalid_o), 32'd0);
    end
    step(); neg();
    check("t2_rvalid", 32'(rvalid_o), 32'd1);
    check("t2_err", 32'(err_o), 32'd0);
    check("t2_rdata", rdata_o, 32'h1234_5678);
    step(); neg();
    check("t2_rdata_hold", rdata_o, 32'h1234_5678);
    check("t2_rvalid_pulse", 32'(rvalid_o), 32'd0);

    // 3: read with slave error
    step(); req_put(32'h108, 32'd0, 4'hF, 1'b0); slv_wait = 0; slv_err = 1'b1;
    slv_rdata = 32'hFFFF_FFFF;
    neg(); step(); req_i = 1'b0;
    neg(); step(); neg(); step(); neg();
    check("t3_rvalid", 32'(rvalid_o), 32'd1);
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_rdata", rdata_o, 32'd0);
    step(); slv_err = 1'b0;

    // 4: timeout with a pending follow-up request held on the port
    req_put(32'h10C, 32'd0, 4'hF, 1'b0); slv_never = 1'b1;
    neg(); check("t4_gnt", 32'(gnt_o), 32'd1);
    step(); req_put(32'h110, 32'hCAFE_F00D, 4'h3, 1'b1);
    neg(); check("t4_setup_paddr", PADDR, 32'h10C);
    for (int k = 0; k < 4; k++) begin
      step(); neg();
      check("t4_psel", 32'(PSEL), 32'd1);
      check("t4_pen", 32'(PENABLE), 32'd1);
      check("t4_gnt_blocked", 32'(gnt_o), 32'd0);
    end
    step(); slv_never = 1'b0;
    neg();
    check("t4_abort_psel", 32'(PSEL), 32'd0);
    check("t4_abort_rvalid", 32'(rvalid_o), 32'd1);
    check("t4_abort_err", 32'(err_o), 32'd1);
    check("t4_abort_rdata", rdata_o, 32'd0);
    check("t4_next_gnt", 32'(gnt_o), 32'd1);
    step(); req_i = 1'b0;
    neg(); check("t4_next_paddr", PADDR, 32'h110);
    check("t4_next_pstrb", 32'(PSTRB), 32'h3);
    step(); neg(); step(); neg();
    check("t4_next_rvalid", 32'(rvalid_o), 32'd1);
    check("t4_next_err", 32'(err_o), 32'd0);

    // 5: three back-to-back writes
    step(); req_put(32'h200, 32'd1, 4'hF, 1'b1);
    grants = 0; g_bits = 8'd0; s_bits = 8'd0; e_bits = 8'd0; v_bits = 8'd0;
    for (int c = 0; c < 8; c++) begin
      neg();
      g = gnt_o;
      g_bits[c] = gnt_o; s_bits[c] = PSEL; e_bits[c] = PENABLE; v_bits[c] = rvalid_o;
      step();
      if (g) begin
        grants++;
        if (grants == 3) req_i = 1'b0;
        else req_put(32'h200 + 32'(4 * grants), 32'(grants + 1), 4'hF, 1'b1);
      end
    end
    check("t5_gnt_pattern", 32'(g_bits), 32'h15);
    check("t5_psel_pattern", 32'(s_bits), 32'h7E);
    check("t5_pen_pattern", 32'(e_bits), 32'h54);
    check("t5_rvalid_pattern", 32'(v_bits), 32'hA8);
    check("t5_last_paddr", PADDR, 32'h208);

    // 6: asynchronous reset in the middle of ACCESS
    req_put(32'h300, 32'd0, 4'hF, 1'b0); slv_never = 1'b1;
    neg(); step(); req_i = 1'b0;
    neg(); step(); neg(); step(); neg();
    check("t6_pre_pen", 32'(PENABLE), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("t6_async_psel", 32'(PSEL), 32'd0);
    check("t6_async_pen", 32'(PENABLE), 32'd0);
    check("t6_async_rvalid", 32'(rvalid_o), 32'd0);
    neg(); rst_i = 1'b0; slv_never = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); neg();
      check("t6_idle_psel", 32'(PSEL), 32'd0);
      check("t6_no_rvalid", 32'(rvalid_o), 32'd0);
    end
    step(); req_put(32'h304, 32'd0, 4'hF, 1'b0); slv_wait = 1; slv_rdata = 32'h0BAD_CAFE;
    neg(); check("t6_post_gnt", 32'(gnt_o), 32'd1);
    step(); req_i = 1'b0;
    neg(); step(); neg(); step(); neg(); step(); neg();
    check("t6_post_rvalid", 32'(rvalid_o), 32'd1);
    check("t6_post_rdata", rdata_o, 32'h0BAD_CAFE);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
